// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with byte-addressed data memory, byte/half/word
// loads and stores, load sign/zero extension, configurable wait states that stall the
// pipeline, a registered branch decision and detection of misaligned or out-of-range
// accesses.
// Optional feature: define MEM_ACCESS_STATS_EN to add saturating statistics counters
// (stat_reads, stat_writes, stat_stalls, stat_faults).
module mem_access_stage #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_branch_ex_mem,
    input  logic              ctrl_branchNe_ex_mem,
    input  logic              zero_ex_mem,
    input  logic              ctrl_memRead_ex_mem,
    input  logic              ctrl_memWrite_ex_mem,
    input  logic [1:0]        ctrl_memSize_ex_mem,
    input  logic              ctrl_memUnsigned_ex_mem,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       write_data_into_mem,
    output logic              ctrl_pcSrc,
    output logic [31:0]       read_data_from_mem,
    output logic              read_valid,
    output logic              mem_stall,
    output logic              mem_fault
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_stalls,
    output logic [31:0]       stat_faults
`endif
);

    // ADDR_W-2 must be at least $clog2(DEPTH) so every word is addressable
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [31:0]      r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic             w_req;
    logic             w_stall;
    logic             w_access;
    logic [IDX_W-1:0] w_word_idx;
    logic [AW-1:0]    w_mem_idx;
    logic [1:0]       w_lane;
    logic             w_oob;
    logic             w_misalign;
    logic             w_fault_cond;
    logic             w_do_write;
    logic             w_do_read;
    logic             w_do_fault;
    logic             w_branch_taken;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_lanes;
    logic [31:0]      w_rd_word;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [31:0]      w_load_ext;

    assign w_req      = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    assign w_word_idx = mem_address[ADDR_W-1:2];
    assign w_lane     = mem_address[1:0];
    assign w_mem_idx  = w_word_idx[AW-1:0];

    // Out of range when any word-index bit above the array size is set (DEPTH is a power of 2)
    generate
        if (IDX_W > AW) begin : g_oob
            assign w_oob = |w_word_idx[IDX_W-1:AW];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    // Alignment and size legality
    always_comb begin
        w_misalign = 1'b0;
        case (ctrl_memSize_ex_mem)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = w_lane[0];
            SZ_WORD: w_misalign = |w_lane;
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_fault_cond = w_misalign | w_oob;

    // Next-state logic: WAIT_CYCLES stall cycles, then the access edge
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_next_cnt   = CNT_W'(WAIT_CYCLES - 1);
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_stall    = 1'b1;
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_access     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Write wins over read; a held reset blocks the un-reset memory array from writing
    assign w_do_write = w_access & ctrl_memWrite_ex_mem & ~w_fault_cond & ~reset;
    assign w_do_read  = w_access & ctrl_memRead_ex_mem & ~ctrl_memWrite_ex_mem & ~w_fault_cond;
    assign w_do_fault = w_access & w_req & w_fault_cond;

    assign w_branch_taken = ctrl_branch_ex_mem & (zero_ex_mem ^ ctrl_branchNe_ex_mem);

    assign mem_stall = w_stall & ~reset;

    // Store lane enables and lane-replicated store data
    always_comb begin
        w_be          = 4'b0000;
        w_wdata_lanes = write_data_into_mem;
        case (ctrl_memSize_ex_mem)
            SZ_BYTE: begin
                w_be          = 4'b0001 << w_lane;
                w_wdata_lanes = {4{write_data_into_mem[7:0]}};
            end
            SZ_HALF: begin
                w_be          = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{write_data_into_mem[15:0]}};
            end
            SZ_WORD: begin
                w_be = 4'b1111;
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    assign w_rd_word = r_mem[w_mem_idx];

    // Load lane select and extension
    always_comb begin
        w_ld_byte = w_rd_word[7:0];
        case (w_lane)
            2'd1:    w_ld_byte = w_rd_word[15:8];
            2'd2:    w_ld_byte = w_rd_word[23:16];
            2'd3:    w_ld_byte = w_rd_word[31:24];
            default: w_ld_byte = w_rd_word[7:0];
        endcase
        w_ld_half  = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_ext = w_rd_word;
        case (ctrl_memSize_ex_mem)
            SZ_BYTE: w_load_ext = {{24{~ctrl_memUnsigned_ex_mem & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: w_load_ext = {{16{~ctrl_memUnsigned_ex_mem & w_ld_half[15]}}, w_ld_half};
            default: w_load_ext = w_rd_word;
        endcase
    end

    // Data memory array: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // State register and registered stage outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            ctrl_pcSrc         <= 1'b0;
            read_data_from_mem <= '0;
            read_valid         <= 1'b0;
            mem_fault          <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            ctrl_pcSrc <= w_stall ? 1'b0 : w_branch_taken;
            read_valid <= w_do_read;
            mem_fault  <= w_do_fault;
            if (w_do_read) begin
                read_data_from_mem <= w_load_ext;
            end
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating access, stall and fault statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
            stat_faults <= '0;
        end else begin
            stat_reads  <= sat_inc(stat_reads, w_do_read);
            stat_writes <= sat_inc(stat_writes, w_do_write);
            stat_stalls <= sat_inc(stat_stalls, w_stall);
            stat_faults <= sat_inc(stat_faults, w_do_fault);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: three instances (WAIT_CYCLES 0, 3, 2) checked every cycle against
// a byte-level transaction model, plus hand-computed literal expectations.
module tb_mem_access_stage;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NB    = 4 * DEPTH;
    localparam int          NDUT  = 3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        br;
        logic        bne;
        logic        zero;
    } op_t;

    logic        clk;
    logic        reset;
    op_t         in_op    [NDUT];
    logic        o_pcsrc  [NDUT];
    logic [31:0] o_rdata  [NDUT];
    logic        o_rvalid [NDUT];
    logic        o_stall  [NDUT];
    logic        o_fault  [NDUT];

    bit          e_pcsrc  [NDUT];
    logic [31:0] e_rdata  [NDUT];
    bit          e_rvalid [NDUT];
    bit          e_stall  [NDUT];
    bit          e_fault  [NDUT];

    int n_stall  [NDUT];
    int n_rvalid [NDUT];
    int n_pcsrc  [NDUT];

    logic [7:0] mdl [NDUT][NB];

    int errors;
    int checks;
    bit chk_en;

`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] o_sr [NDUT];
    logic [31:0] o_sw [NDUT];
    logic [31:0] o_ss [NDUT];
    logic [31:0] o_sf [NDUT];
    logic [31:0] e_sr [NDUT];
    logic [31:0] e_sw [NDUT];
    logic [31:0] e_ss [NDUT];
    logic [31:0] e_sf [NDUT];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            mem_access_stage #(
                .ADDR_W     (32),
                .DEPTH      (DEPTH),
                .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
            ) u_dut (
                .clk                    (clk),
                .reset                  (reset),
                .ctrl_branch_ex_mem     (in_op[g].br),
                .ctrl_branchNe_ex_mem   (in_op[g].bne),
                .zero_ex_mem            (in_op[g].zero),
                .ctrl_memRead_ex_mem    (in_op[g].rd),
                .ctrl_memWrite_ex_mem   (in_op[g].wr),
                .ctrl_memSize_ex_mem    (in_op[g].sz),
                .ctrl_memUnsigned_ex_mem(in_op[g].uns),
                .mem_address            (in_op[g].addr),
                .write_data_into_mem    (in_op[g].wdata),
                .ctrl_pcSrc             (o_pcsrc[g]),
                .read_data_from_mem     (o_rdata[g]),
                .read_valid             (o_rvalid[g]),
                .mem_stall              (o_stall[g]),
                .mem_fault              (o_fault[g])
`ifdef MEM_ACCESS_STATS_EN
                ,
                .stat_reads             (o_sr[g]),
                .stat_writes            (o_sw[g]),
                .stat_stalls            (o_ss[g]),
                .stat_faults            (o_sf[g])
`endif
            );
        end
    endgenerate

    function automatic int wait_of(input int id);
        case (id)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] a, input logic [31:0] d);
        op_t o = '0;
        o.rd = rd; o.wr = wr; o.sz = sz; o.uns = uns; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic op_t mkbr(input logic bne, input logic zero);
        op_t o = '0;
        o.br = 1'b1; o.bne = bne; o.zero = zero;
        return o;
    endfunction

    task automatic check32(input string name, input int id, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Model of one clock edge: the named instance sees op (stalled or accessing),
    // the others are idle.
    task automatic edge_update(input int id, input op_t op, input bit stalled);
        int  n;
        bit  bad;
        logic [31:0] v;
        for (int k = 0; k < NDUT; k++) begin
            e_pcsrc[k]  = 1'b0;
            e_rvalid[k] = 1'b0;
            e_fault[k]  = 1'b0;
        end
        e_pcsrc[id] = !stalled && op.br && (op.zero ^ op.bne);
`ifdef MEM_ACCESS_STATS_EN
        if (stalled) e_ss[id] = e_ss[id] + 32'd1;
`endif
        if (!stalled && (op.rd || op.wr)) begin
            case (op.sz)
                2'd0:    n = 1;
                2'd1:    n = 2;
                default: n = 4;
            endcase
            bad = (op.sz == 2'd3) || (op.sz == 2'd1 && op.addr[0]) ||
                  (op.sz == 2'd2 && op.addr[1:0] != 2'd0) || (op.addr >= 32'(NB));
            if (bad) begin
                e_fault[id] = 1'b1;
`ifdef MEM_ACCESS_STATS_EN
                e_sf[id] = e_sf[id] + 32'd1;
`endif
            end else if (op.wr) begin
                for (int i = 0; i < n; i++) mdl[id][op.addr + 32'(i)] = op.wdata[8*i +: 8];
`ifdef MEM_ACCESS_STATS_EN
                e_sw[id] = e_sw[id] + 32'd1;
`endif
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[id][op.addr + 32'(i)];
                if (!op.uns && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e_rdata[id]  = v;
                e_rvalid[id] = 1'b1;
`ifdef MEM_ACCESS_STATS_EN
                e_sr[id] = e_sr[id] + 32'd1;
`endif
            end
        end
    endtask

    // Present op on one instance for its full stall + access span
    task automatic run_op(input int id, input op_t op);
        int ncyc;
        ncyc = (op.rd || op.wr) ? wait_of(id) + 1 : 1;
        in_op[id] = op;
        for (int j = 0; j < ncyc; j++) begin
            e_stall[id] = (j < ncyc - 1);
            @(posedge clk);
            edge_update(id, op, (j < ncyc - 1));
            #1;
        end
        in_op[id]   = '0;
        e_stall[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            edge_update(0, '0, 1'b0);
            #1;
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < NDUT; k++) begin
            e_pcsrc[k] = 1'b0; e_rdata[k] = '0; e_rvalid[k] = 1'b0;
            e_stall[k] = 1'b0; e_fault[k] = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
            e_sr[k] = '0; e_sw[k] = '0; e_ss[k] = '0; e_sf[k] = '0;
`endif
        end
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                check32("pcsrc",  k, 32'(o_pcsrc[k]),  32'(e_pcsrc[k]));
                check32("rdata",  k, o_rdata[k],       e_rdata[k]);
                check32("rvalid", k, 32'(o_rvalid[k]), 32'(e_rvalid[k]));
                check32("stall",  k, 32'(o_stall[k]),  32'(e_stall[k]));
                check32("fault",  k, 32'(o_fault[k]),  32'(e_fault[k]));
`ifdef MEM_ACCESS_STATS_EN
                check32("stat_reads",  k, o_sr[k], e_sr[k]);
                check32("stat_writes", k, o_sw[k], e_sw[k]);
                check32("stat_stalls", k, o_ss[k], e_ss[k]);
                check32("stat_faults", k, o_sf[k], e_sf[k]);
`endif
                if (o_stall[k] === 1'b1)  n_stall[k]++;
                if (o_rvalid[k] === 1'b1) n_rvalid[k]++;
                if (o_pcsrc[k] === 1'b1)  n_pcsrc[k]++;
            end
        end
    end

    initial begin
        op_t op;
        int  s0, r0;
        errors = 0;
        checks = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_op[k] = '0;
            n_stall[k] = 0; n_rvalid[k] = 0; n_pcsrc[k] = 0;
            for (int b = 0; b < int'(NB); b++) mdl[k][b] = 8'h00;
        end
        clear_exp();
        #1 chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check32("rst rdata", 0, o_rdata[0], 32'h0);
        check32("rst rvalid", 1, 32'(o_rvalid[1]), 32'h0);
        reset = 1'b0;
        idle(1);

        // 1: word store then load, no wait states
        s0 = n_stall[0]; r0 = n_rvalid[0];
        run_op(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF));
        run_op(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
        check32("t1 lw", 0, o_rdata[0], 32'hDEADBEEF);
        idle(1);
        check32("t1 rvalid pulses", 0, 32'(n_rvalid[0] - r0), 32'd1);
        check32("t1 stall cycles", 0, 32'(n_stall[0] - s0), 32'd0);

        // 2: byte and half lanes with extension
        run_op(0, mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000F0));
        run_op(0, mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0));
        check32("t2 lb", 0, o_rdata[0], 32'hFFFFFFF0);
        run_op(0, mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0));
        check32("t2 lbu", 0, o_rdata[0], 32'h000000F0);
        run_op(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
        check32("t2 lw", 0, o_rdata[0], 32'hF0ADBEEF);
        run_op(0, mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0));
        check32("t2 lb lane1", 0, o_rdata[0], 32'hFFFFFFBE);
        run_op(0, mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0));
        check32("t2 lh", 0, o_rdata[0], 32'hFFFFF0AD);
        run_op(0, mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0));
        check32("t2 lhu", 0, o_rdata[0], 32'h0000F0AD);
        run_op(0, mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234));
        run_op(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
        check32("t2 sh lw", 0, o_rdata[0], 32'h1234BEEF);

        // 3: rejected accesses leave memory and read data untouched
        run_op(0, mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0));
        check32("t3 lh odd fault", 0, 32'(o_fault[0]), 32'd1);
        run_op(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF));
        check32("t3 sw misalign fault", 0, 32'(o_fault[0]), 32'd1);
        run_op(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'(NB), 32'h0));
        check32("t3 oob fault", 0, 32'(o_fault[0]), 32'd1);
        check32("t3 rdata held", 0, o_rdata[0], 32'h1234BEEF);
        run_op(0, mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0));
        check32("t3 size11 fault", 0, 32'(o_fault[0]), 32'd1);
        idle(1);
        run_op(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
        check32("t3 mem intact", 0, o_rdata[0], 32'h1234BEEF);
        idle(1);

        // 4: three wait states, back-to-back loads
        run_op(1, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A50001));
        s0 = n_stall[1]; r0 = n_rvalid[1];
        run_op(1, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0));
        check32("t4 lw", 1, o_rdata[1], 32'hA5A50001);
        run_op(1, mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0));
        check32("t4 lh", 1, o_rdata[1], 32'hFFFFA5A5);
        idle(1);
        check32("t4 stall cycles", 1, 32'(n_stall[1] - s0), 32'd6);
        check32("t4 rvalid pulses", 1, 32'(n_rvalid[1] - r0), 32'd2);

        // 5: branch decision
        run_op(0, mkbr(1'b0, 1'b1));
        check32("t5 beq z1", 0, 32'(o_pcsrc[0]), 32'd1);
        run_op(0, mkbr(1'b1, 1'b1));
        check32("t5 bne z1", 0, 32'(o_pcsrc[0]), 32'd0);
        run_op(0, mkbr(1'b1, 1'b0));
        check32("t5 bne z0", 0, 32'(o_pcsrc[0]), 32'd1);
        run_op(0, mkbr(1'b0, 1'b0));
        check32("t5 beq z0", 0, 32'(o_pcsrc[0]), 32'd0);
        s0 = n_pcsrc[2]; r0 = n_stall[2];
        op = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h00000077);
        op.br = 1'b1; op.zero = 1'b1;
        run_op(2, op);
        idle(2);
        check32("t5 taken once", 2, 32'(n_pcsrc[2] - s0), 32'd1);
        check32("t5 stall cycles", 2, 32'(n_stall[2] - r0), 32'd2);

        // 6: reset during the wait of a pending store
        run_op(1, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344));
        op = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        in_op[1] = op;
        for (int j = 0; j < 2; j++) begin
            e_stall[1] = 1'b1;
            @(posedge clk);
            edge_update(1, op, 1'b1);
            #1;
        end
        #2;
        in_op[1] = '0;
        reset = 1'b1;
        clear_exp();
        @(posedge clk); #1;
        check32("t6 rst stall", 1, 32'(o_stall[1]), 32'd0);
        check32("t6 rst rdata", 1, o_rdata[1], 32'd0);
`ifdef MEM_ACCESS_STATS_EN
        check32("t6 rst stat_reads", 1, o_sr[1], 32'd0);
        check32("t6 rst stat_stalls", 1, o_ss[1], 32'd0);
`endif
        reset = 1'b0;
        idle(1);
        s0 = n_stall[1];
        run_op(1, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0));
        check32("t6 no write", 1, o_rdata[1], 32'h11223344);
        idle(1);
        check32("t6 stall cycles", 1, 32'(n_stall[1] - s0), 32'd3);
`ifdef MEM_ACCESS_STATS_EN
        check32("t6 stat_reads", 1, o_sr[1], 32'd1);
        check32("t6 stat_stalls", 1, o_ss[1], 32'd3);
`endif
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Parametrised MEM-stage unit for the MIPS pipeline. It provides byte-addressed data memory with byte, half and word loads and stores, and sign or zero extension on loads. Configurable wait states stall the pipeline. It registers the branch decision (beq/bne) and flags misaligned or out-of-range accesses. It sits between the EX/MEM and MEM/WB pipeline registers.

Parameters:
ADDR_W, 32, byte-address width of mem_address.
DEPTH, 1024, number of 32-bit words (power of 2, at least 4).
WAIT_CYCLES, 0, extra cycles per memory access (0..15); the pipeline is stalled for exactly this many cycles.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ctrl_branch_ex_mem  in  1  branch instruction
ctrl_branchNe_ex_mem  in  1  1 = bne, 0 = beq (qualified by ctrl_branch_ex_mem)
zero_ex_mem  in  1  ALU zero flag
ctrl_memRead_ex_mem  in  1  load request
ctrl_memWrite_ex_mem  in  1  store request
ctrl_memSize_ex_mem  in  2  00 byte, 01 half, 10 word, 11 illegal
ctrl_memUnsigned_ex_mem  in  1  zero-extend loads (lbu/lhu)
mem_address  in  ADDR_W  byte address
write_data_into_mem  in  32  store data, right-aligned
ctrl_pcSrc  out  1  registered branch-taken
read_data_from_mem  out  32  registered, extended load result
read_valid  out  1  one-cycle pulse: read_data_from_mem updated
mem_stall  out  1  combinational; upstream holds EX/MEM while high
mem_fault  out  1  one-cycle pulse: access rejected

Behaviour:
- Reset values: ctrl_pcSrc=0, read_data_from_mem=0, read_valid=0, mem_fault=0. FSM goes to IDLE and the wait counter to 0.
- Memory array contents are NOT reset.
- Reset mid-access abandons the access: no write occurs and no pulse is produced.
- Request: req = memRead | memWrite. If both are set, the write wins and no read is performed.
- Word index is mem_address[ADDR_W-1:2]. Byte lane is mem_address[1:0], little-endian (lane 0 = bits 7:0).
- Fault conditions, checked at the access edge:
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - word index >= DEPTH.
- On fault: no write, read_data_from_mem unchanged, read_valid=0, mem_fault=1 for one cycle.
- Store: only the addressed lanes are written (byte: 1 lane, half: lanes {addr[1],0}/+1, word: all 4), using the low bits of write_data_into_mem.
- Load: select lanes, then zero-extend if memUnsigned=1, else sign-extend. Result is registered; read_valid pulses the cycle after the access edge.
- FSM states:
  - IDLE, req=0: no action, mem_stall=0.
  - IDLE, req=1, WAIT_CYCLES=0: access at this edge, stay IDLE, mem_stall=0.
  - IDLE, req=1, WAIT_CYCLES>0: mem_stall=1; at edge cnt<=WAIT_CYCLES-1 and go to WAIT.
  - WAIT, cnt!=0: mem_stall=1, cnt decrements.
  - WAIT, cnt==0: mem_stall=0; access at edge, return to IDLE. The pipeline advances on the same edge.
- Result: exactly WAIT_CYCLES stall cycles per request. Back-to-back requests are serviced with no bubble beyond the stalls.
- Branch: on every non-stalled edge, ctrl_pcSrc <= ctrl_branch_ex_mem & (zero_ex_mem ^ ctrl_branchNe_ex_mem). On stalled edges ctrl_pcSrc <= 0, so a branch is taken exactly once.
- Write-then-read of the same address in consecutive requests returns the new data.

Optional Feature:
MEM_ACCESS_STATS_EN
- Defined: adds outputs stat_reads[31:0], stat_writes[31:0], stat_stalls[31:0] and stat_faults[31:0].
  - stat_reads and stat_writes count completed non-faulting accesses.
  - stat_stalls counts cycles with mem_stall=1.
  - stat_faults counts mem_fault pulses.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
1. WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> read_data=0xDEADBEEF, read_valid pulses once, mem_stall never high.
2. Store 0x000000F0 as byte @0x13, then lb @0x13 -> 0xFFFFFFF0; lbu @0x13 -> 0x000000F0; lw @0x10 -> 0xF0ADBEEF (after test 1).
3. lh @0x11, sw @0x12, and lw @ byte address 4*DEPTH -> mem_fault pulse each time; memory and read_data unchanged.
4. WAIT_CYCLES=3: lw held with the EX/MEM register -> mem_stall high exactly 3 cycles, read_valid in cycle 5; a back-to-back second lw stalls 3 more cycles.
5. beq zero=1 -> ctrl_pcSrc=1 next cycle. bne zero=1 -> 0. bne zero=0 -> 1. A branch during a WAIT_CYCLES=2 stall -> ctrl_pcSrc asserts only once.
6. Assert reset during WAIT of a pending sw @0x20 -> no write (lw @0x20 returns the prior value), all outputs 0, FSM IDLE; with MEM_ACCESS_STATS_EN, counters read 0.
